// File: rtl/timer_pkg.sv
// Shared constants for the multi-channel APB timer: register offsets inside a
// channel window and bit positions inside TCR and TSR.
package timer_pkg;

    // Register offset inside a 4-word channel window (addr = ch*4 + off)
    typedef enum logic [1:0] {
        OFF_TDR  = 2'd0,
        OFF_TCR  = 2'd1,
        OFF_TSR  = 2'd2,
        OFF_TCNT = 2'd3
    } reg_off_e;

    // TCR bit positions
    localparam int TCR_LOAD    = 7;
    localparam int TCR_AR      = 6;
    localparam int TCR_DN      = 5;
    localparam int TCR_EN      = 4;
    localparam int TCR_IE      = 3;
    localparam int TCR_CKS_MSB = 2;
    localparam int TCR_CKS_LSB = 0;

    // TSR bit positions
    localparam int TSR_OVF = 0;
    localparam int TSR_UDF = 1;

    // Width of the shared free-running prescaler
    localparam int PSC_W = 8;

endpackage

// File: rtl/timer_nch_apb_if.sv
// APB slave bus bundle for the timer. The requester drives the
// select/enable/address/data fields; the timer answers with read data,
// ready and error.
interface timer_nch_apb_if #(
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [CNT_W-1:0]  pwdata;
    logic [CNT_W-1:0]  prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/timer_channel.sv
// One timer channel: TDR/TCR/TSR/TCNT registers, prescaler tap selection,
// up/down counting with wrap/auto-reload, sticky flags and registered irq.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PSC_W-1:0] psc,
    input  logic [PSC_W-1:0] psc_prev,
    input  logic             wr_en,
    input  reg_off_e         wr_off,
    input  logic [CNT_W-1:0] wdata,
    output logic [CNT_W-1:0] tdr,
    output logic [7:0]       tcr,
    output logic [1:0]       tsr,
    output logic [CNT_W-1:0] tcnt,
    output logic             irq
);

    logic [CNT_W-1:0] tdr_q, tdr_d;
    logic [7:0]       tcr_q, tcr_d;
    logic [1:0]       tsr_q, tsr_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             irq_q, irq_d;
    logic [2:0]       cks;
    logic             tick;

    // Next-state: bus writes first, then counting; a flag set overrides a W1C clear
    always_comb begin
        tdr_d  = tdr_q;
        tcr_d  = tcr_q;
        tsr_d  = tsr_q;
        tcnt_d = tcnt_q;
        cks    = tcr_q[TCR_CKS_MSB:TCR_CKS_LSB];
        // Falling edge of the selected prescaler bit: one tick per 2^(cks+1) clocks
        tick   = psc_prev[cks] & ~psc[cks];

        if (wr_en) begin
            case (wr_off)
                OFF_TDR: tdr_d = wdata;
                OFF_TCR: tcr_d = wdata[7:0];
                OFF_TSR: tsr_d = tsr_q & ~wdata[1:0];
                default: ;
            endcase
        end

        if (tcr_q[TCR_LOAD]) begin
            tcnt_d = tdr_q;
        end else if (tcr_q[TCR_EN] && tick) begin
            if (tcr_q[TCR_DN]) begin
                if (tcnt_q == '0) begin
                    tcnt_d         = tcr_q[TCR_AR] ? tdr_q : '1;
                    tsr_d[TSR_UDF] = 1'b1;
                end else begin
                    tcnt_d = tcnt_q - CNT_W'(1);
                end
            end else begin
                if (tcnt_q == '1) begin
                    tcnt_d         = tcr_q[TCR_AR] ? tdr_q : '0;
                    tsr_d[TSR_OVF] = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + CNT_W'(1);
                end
            end
        end

        // irq follows the flags one cycle later
        irq_d = tcr_q[TCR_IE] & (|tsr_q);
    end

    // Channel state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tdr_q  <= '0;
            tcr_q  <= '0;
            tsr_q  <= '0;
            tcnt_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            tdr_q  <= tdr_d;
            tcr_q  <= tcr_d;
            tsr_q  <= tsr_d;
            tcnt_q <= tcnt_d;
            irq_q  <= irq_d;
        end
    end

    assign tdr  = tdr_q;
    assign tcr  = tcr_q;
    assign tsr  = tsr_q;
    assign tcnt = tcnt_q;
    assign irq  = irq_q;

endmodule

// File: rtl/timer_nch_apb.sv
// Multi-channel up/down timer behind an APB slave: address decode, read mux,
// shared prescaler and error response. Optional macro TIMER_PSLVERR_EN
// enables pslverr for invalid addresses and writes to TCNT.
module timer_nch_apb
    import timer_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 8
) (
    input  logic                pclk,
    input  logic                presetn,
    timer_nch_apb_if.slave      apb,
    output logic [NUM_CH-1:0]   irq
);

    logic [PSC_W-1:0]  psc_q, psc_d;
    logic [PSC_W-1:0]  psc_prev_q, psc_prev_d;
    logic [ADDR_W-1:0] ch_idx;
    reg_off_e          off;
    logic              access;
    logic              wr;
    logic              addr_ok;
    logic [NUM_CH-1:0] wr_ch;
    logic [CNT_W-1:0]  rdata;

    logic [CNT_W-1:0]  tdr_a  [NUM_CH];
    logic [7:0]        tcr_a  [NUM_CH];
    logic [1:0]        tsr_a  [NUM_CH];
    logic [CNT_W-1:0]  tcnt_a [NUM_CH];

    // Address decode and per-channel write strobes
    always_comb begin
        ch_idx  = apb.paddr >> 2;
        off     = reg_off_e'(apb.paddr[1:0]);
        access  = apb.psel & apb.penable;
        wr      = access & apb.pwrite;
        addr_ok = (ch_idx < ADDR_W'(NUM_CH));
        psc_d      = psc_q + PSC_W'(1);
        psc_prev_d = psc_q;
        wr_ch   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_ch[i] = wr & addr_ok & (ch_idx == ADDR_W'(i));
        end
    end

    // Free-running prescaler plus its previous value for edge detection
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            psc_q      <= '0;
            psc_prev_q <= '0;
        end else begin
            psc_q      <= psc_d;
            psc_prev_q <= psc_prev_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        timer_channel #(.CNT_W(CNT_W)) u_ch (
            .clk      (pclk),
            .rst_n    (presetn),
            .psc      (psc_q),
            .psc_prev (psc_prev_q),
            .wr_en    (wr_ch[g]),
            .wr_off   (off),
            .wdata    (apb.pwdata),
            .tdr      (tdr_a[g]),
            .tcr      (tcr_a[g]),
            .tsr      (tsr_a[g]),
            .tcnt     (tcnt_a[g]),
            .irq      (irq[g])
        );
    end

    // Combinational read mux, zero outside a valid read access phase
    always_comb begin
        rdata = '0;
        if (access && !apb.pwrite && addr_ok) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_idx == ADDR_W'(i)) begin
                    case (off)
                        OFF_TDR:  rdata = tdr_a[i];
                        OFF_TCR:  rdata = CNT_W'(tcr_a[i]);
                        OFF_TSR:  rdata = CNT_W'(tsr_a[i]);
                        OFF_TCNT: rdata = tcnt_a[i];
                        default:  rdata = '0;
                    endcase
                end
            end
        end
    end

    assign apb.prdata = rdata;
    assign apb.pready = 1'b1;

`ifdef TIMER_PSLVERR_EN
    assign apb.pslverr = access & (~addr_ok | (apb.pwrite & (off == OFF_TCNT)));
`else
    assign apb.pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_timer_nch_apb.sv
// Bench for timer_nch_apb: directed scenarios followed by random APB traffic,
// all checked against a cycle-level behavioural model of the register rules.
module tb_timer_nch_apb;

    localparam int     CNT_W  = 16;
    localparam int     NUM_CH = 4;
    localparam int     ADDR_W = 8;
    localparam longint MAXV   = (64'd1 << CNT_W) - 1;

    logic              pclk = 1'b0;
    logic              presetn = 1'b0;
    logic [NUM_CH-1:0] irq;

    timer_nch_apb_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) apb ();

    timer_nch_apb #(.CNT_W(CNT_W), .NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .apb     (apb),
        .irq     (irq)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    longint m_tdr  [NUM_CH];
    longint m_tcnt [NUM_CH];
    longint m_tcr  [NUM_CH];
    longint m_tsr  [NUM_CH];
    longint m_irq  [NUM_CH];
    longint m_t;   // clocks since reset release = prescaler phase

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model of one rising edge, using the bus values currently driven
    function automatic void model_edge();
        longint ntdr, ntcr, ntsr, ncnt, div;
        int     ch, off;
        bit     wr;
        if (!presetn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_tdr[c] = 0; m_tcr[c] = 0; m_tsr[c] = 0; m_tcnt[c] = 0; m_irq[c] = 0;
            end
            m_t = 0;
            return;
        end
        ch = int'(apb.paddr) / 4;
        off = int'(apb.paddr) % 4;
        wr = apb.psel && apb.penable && apb.pwrite;
        for (int c = 0; c < NUM_CH; c++) begin
            ntdr = m_tdr[c]; ntcr = m_tcr[c]; ntsr = m_tsr[c]; ncnt = m_tcnt[c];
            if (wr && ch == c) begin
                if (off == 0) ntdr = longint'(apb.pwdata);
                if (off == 1) ntcr = longint'(apb.pwdata) & 255;
                if (off == 2) ntsr = m_tsr[c] & ~longint'(apb.pwdata) & 3;
            end
            div = 64'd2 << (m_tcr[c] & 7);
            if (m_tcr[c] & 'h80) begin
                ncnt = m_tdr[c];
            end else if ((m_tcr[c] & 'h10) != 0 && m_t > 0 && (m_t % div) == 0) begin
                if (m_tcr[c] & 'h20) begin
                    if (m_tcnt[c] == 0) begin
                        ncnt = (m_tcr[c] & 'h40) ? m_tdr[c] : MAXV;
                        ntsr = ntsr | 2;
                    end else ncnt = m_tcnt[c] - 1;
                end else begin
                    if (m_tcnt[c] == MAXV) begin
                        ncnt = (m_tcr[c] & 'h40) ? m_tdr[c] : 0;
                        ntsr = ntsr | 1;
                    end else ncnt = m_tcnt[c] + 1;
                end
            end
            m_irq[c] = ((m_tcr[c] & 'h08) != 0 && m_tsr[c] != 0) ? 1 : 0;
            m_tdr[c] = ntdr; m_tcr[c] = ntcr; m_tsr[c] = ntsr; m_tcnt[c] = ncnt;
        end
        m_t++;
    endfunction

    function automatic longint model_read(input int addr);
        int ch = addr / 4;
        int off = addr % 4;
        if (ch >= NUM_CH) return 0;
        case (off)
            0: return m_tdr[ch];
            1: return m_tcr[ch];
            2: return m_tsr[ch];
            default: return m_tcnt[ch];
        endcase
    endfunction

    function automatic longint exp_err(input int addr, input bit wr);
`ifdef TIMER_PSLVERR_EN
        return ((addr / 4) >= NUM_CH || (wr && (addr % 4) == 3)) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    // One clock: model follows the edge, irq compared just after it
    task automatic clk_edge();
        @(posedge pclk);
        model_edge();
        #1;
        for (int c = 0; c < NUM_CH; c++)
            chk($sformatf("irq[%0d]", c), 64'(irq[c]), 64'(m_irq[c]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) clk_edge();
    endtask

    task automatic apb_write(input int addr, input longint data);
        logic [63:0] d = data;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
        apb.paddr = ADDR_W'(addr); apb.pwdata = d[CNT_W-1:0];
        clk_edge();
        apb.penable = 1'b1;
        #1;
        chk($sformatf("pslverr_wr@%0h", addr), 64'(apb.pslverr), 64'(exp_err(addr, 1'b1)));
        clk_edge();
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    endtask

    task automatic apb_read(input int addr, output longint data);
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = ADDR_W'(addr);
        clk_edge();
        apb.penable = 1'b1;
        #1;
        chk($sformatf("prdata@%0h", addr), 64'(apb.prdata), 64'(model_read(addr)));
        chk($sformatf("pslverr_rd@%0h", addr), 64'(apb.pslverr), 64'(exp_err(addr, 1'b0)));
        data = longint'(apb.prdata);
        clk_edge();
        apb.psel = 1'b0; apb.penable = 1'b0;
    endtask

    function automatic int ad(input int ch, input int off);
        return ch * 4 + off;
    endfunction

    initial begin
        longint v, a3, a0, b3, b0, u1, u2, w1, w2;
        int     cyc;
        bit     hit;

        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        apb.paddr = '0; apb.pwdata = '0;

        // Reset state
        presetn = 1'b0;
        idle(3);
        chk("irq_reset", 64'(irq), 64'd0);
        chk("prdata_idle", 64'(apb.prdata), 64'd0);
        chk("pslverr_idle", 64'(apb.pslverr), 64'd0);
        chk("pready", 64'(apb.pready), 64'd1);
        presetn = 1'b1;

        // Reset mid-count on ch0
        apb_write(ad(0, 0), 'h00A7);
        apb_write(ad(0, 1), 'h80);
        apb_write(ad(0, 1), 'h33);
        idle(840);
        apb_read(ad(0, 3), v);
        presetn = 1'b0;
        idle(1);
        presetn = 1'b1;
        for (int c = 0; c < NUM_CH; c++)
            for (int o = 0; o < 4; o++) begin
                apb_read(ad(c, o), v);
                chk($sformatf("reset_zero@%0h", ad(c, o)), 64'(v), 64'd0);
            end
        chk("irq_after_reset", 64'(irq), 64'd0);

        // Up overflow on ch1 (div2, irq enabled)
        apb_write(ad(1, 0), 'hFFF0);
        apb_write(ad(1, 1), 'h80);
        apb_write(ad(1, 1), 'h18);
        cyc = 0;
        while (m_tsr[1] == 0 && cyc < 64) begin
            clk_edge();
            cyc++;
        end
        chk("ovf_latency_in_range", 64'(cyc >= 30 && cyc <= 34), 64'd1);
        chk("irq1_before", 64'(irq[1]), 64'd0);
        clk_edge();
        chk("irq1_after_ovf", 64'(irq[1]), 64'd1);
        apb_read(ad(1, 2), v);
        chk("tsr1_ovf", 64'(v), 64'd1);
        apb_read(ad(1, 3), v);

        // Auto-reload down count on ch2
        apb_write(ad(2, 0), 5);
        apb_write(ad(2, 1), 'h80);
        apb_write(ad(2, 1), 'h50);
        apb_write(ad(2, 1), 'h70);
        for (int i = 0; i < 20; i++) begin
            apb_read(ad(2, 3), v);
            chk("ar_never_max", 64'(v != MAXV && v <= 5), 64'd1);
        end
        apb_read(ad(2, 2), v);
        chk("tsr2_udf", 64'(v), 64'd2);

        // Channel independence: ch0 div256, ch3 div2, ch1/ch2 stopped
        apb_write(ad(1, 1), 0);
        apb_write(ad(2, 1), 0);
        apb_write(ad(0, 1), 'h17);
        apb_write(ad(3, 1), 'h10);
        apb_read(ad(1, 3), u1);
        apb_read(ad(2, 3), u2);
        apb_read(ad(3, 3), a3);
        apb_read(ad(0, 3), a0);
        idle(508);
        apb_read(ad(3, 3), b3);
        apb_read(ad(0, 3), b0);
        apb_read(ad(1, 3), w1);
        apb_read(ad(2, 3), w2);
        chk("ch3_delta", 64'(((b3 - a3) & MAXV) >= 255 && ((b3 - a3) & MAXV) <= 257), 64'd1);
        chk("ch0_delta", 64'(((b0 - a0) & MAXV) >= 1 && ((b0 - a0) & MAXV) <= 3), 64'd1);
        chk("ch1_frozen", 64'(w1), 64'(u1));
        chk("ch2_frozen", 64'(w2), 64'(u2));
        apb_write(ad(0, 1), 0);
        apb_write(ad(3, 1), 0);

        // W1C clear colliding with a fresh underflow on ch2
        apb_write(ad(2, 0), 3);
        apb_write(ad(2, 1), 'h80);
        apb_write(ad(2, 1), 'h78);
        apb_write(ad(2, 2), 3);
        hit = 1'b0;
        for (int i = 0; i < 64 && !hit; i++) begin
            if (m_tcnt[2] == 0 && ((m_t + 1) % 2) == 0) hit = 1'b1;
            else clk_edge();
        end
        chk("collision_found", 64'(hit), 64'd1);
        apb_write(ad(2, 2), 2);
        apb_read(ad(2, 2), v);
        chk("set_wins_clear", 64'(v & 2), 64'd2);
        apb_write(ad(2, 1), 'h68);
        apb_write(ad(2, 2), 2);
        chk("irq2_still_high", 64'(irq[2]), 64'd1);
        clk_edge();
        chk("irq2_dropped", 64'(irq[2]), 64'd0);
        apb_read(ad(2, 2), v);
        chk("tsr2_cleared", 64'(v), 64'd0);

        // Invalid accesses are ignored
        apb_write('h14, 'h1234);
        apb_write('h03, 'h1234);
        apb_read('h14, v);
        chk("invalid_read_zero", 64'(v), 64'd0);
        for (int c = 0; c < NUM_CH; c++)
            for (int o = 0; o < 4; o++) apb_read(ad(c, o), v);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            int  addr = int'($urandom_range(0, 4 * NUM_CH + 3));
            int  kind = int'($urandom_range(0, 9));
            longint dat = longint'($urandom_range(0, 32'(MAXV)));
            if (addr % 4 == 1 && ($urandom_range(0, 1) == 1))
                dat = (dat & 'h6F) | 'h10;
            if (kind < 4) apb_write(addr, dat);
            else if (kind < 8) apb_read(addr, v);
            else if (kind == 8) idle(int'($urandom_range(1, 20)));
            else if ($urandom_range(0, 9) == 0) begin
                presetn = 1'b0;
                idle(1);
                presetn = 1'b1;
            end
        end
        for (int c = 0; c < NUM_CH; c++)
            for (int o = 0; o < 4; o++) apb_read(ad(c, o), v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
